// File: rtl/programmable_clock_divider.sv
// programmable_clock_divider: runtime-loadable divider with near-50% duty cout, period-start tick and boundary-aligned divisor swap
//   cin         rising-edge input clock
//   rst         asynchronous active-high reset
//   en          count enable; when low, all state holds and tick stays low
//   div_in      new divisor (values below 2 are clamped to 2)
//   div_load    captures div_in; taken at once on a boundary edge, otherwise queued
//   cout        divided clock, high for ceil(D/2) input cycles
//   tick        one-cycle pulse at the start of each output period
//   div_active  divisor currently in effect
//   div_pending a queued divisor waits for the next boundary
module programmable_clock_divider #(
  parameter int WIDTH = 32,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             cin,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             cout,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             div_pending
);
  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'((DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV);
  logic [WIDTH-1:0] cnt_q, cnt_d, div_act_q, div_act_d, pend_q, pend_d, ld_val, half;
  logic             cout_q, cout_d, tick_q, tick_d, pend_v_q, pend_v_d, bnd;
  always_comb begin
    ld_val = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
    // ceil(D/2) without forming D+1, so D = 2^WIDTH-1 cannot overflow
    half = (div_act_q >> 1) + WIDTH'(div_act_q[0]);
    bnd = en && (cnt_q == div_act_q - WIDTH'(1));
    cnt_d = cnt_q;
    cout_d = cout_q;
    tick_d = 1'b0;
    div_act_d = div_act_q;
    pend_d = div_load ? ld_val : pend_q;
    pend_v_d = pend_v_q;
    if (bnd) begin
      cnt_d = '0;
      cout_d = 1'b1;
      tick_d = 1'b1;
      // a load on the boundary edge itself wins over any queued value
      div_act_d = div_load ? ld_val : (pend_v_q ? pend_q : div_act_q);
      pend_v_d = 1'b0;
    end else begin
      if (en) begin
        cnt_d = cnt_q + WIDTH'(1);
        cout_d = (cnt_d == half) ? 1'b0 : cout_q;
      end
      pend_v_d = div_load ? 1'b1 : pend_v_q;
    end
  end
  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      cnt_q <= DEF_DIV - WIDTH'(1);
      cout_q <= 1'b0;
      tick_q <= 1'b0;
      div_act_q <= DEF_DIV;
      pend_q <= '0;
      pend_v_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cout_q <= cout_d;
      tick_q <= tick_d;
      div_act_q <= div_act_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end
  assign cout = cout_q;
  assign tick = tick_q;
  assign div_active = div_act_q;
  assign div_pending = pend_v_q;
endmodule

// File: tb/tb_programmable_clock_divider.sv
// tb_programmable_clock_divider: directed checks of reset, divisor loading, clamping, enable freeze and async reset
module tb_programmable_clock_divider;
  logic        cin = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] div_in = '0;
  logic        div_load = 1'b0;
  logic        cout, tick, div_pending;
  logic [31:0] div_active;
  int checks = 0;
  int errors = 0;
  programmable_clock_divider #(.WIDTH(32), .DEFAULT_DIV(2)) dut (
    .cin(cin), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .cout(cout), .tick(tick), .div_active(div_active), .div_pending(div_pending)
  );
  always #5 cin = ~cin;
  task automatic cyc();
    @(posedge cin);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  task automatic test_reset();
    #12;
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++; if (div_active !== 32'd2) begin errors++; $display("FAIL reset_div_active: got %0d expected 2", div_active); end
    checks++; if (div_pending !== 1'b0) begin errors++; $display("FAIL reset_div_pending: got %b expected 0", div_pending); end
    @(negedge cin);
    rst = 1'b0;
    cyc();
    checks++; if (cout !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL idle_en0: got cout=%b tick=%b expected 0 0", cout, tick); end
  endtask
  task automatic test_default();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (cout !== ((i % 2) == 0)) begin errors++; $display("FAIL d2_cout[%0d]: got %b expected %b", i, cout, (i % 2) == 0); end
      checks++; if (tick !== ((i % 2) == 0)) begin errors++; $display("FAIL d2_tick[%0d]: got %b expected %b", i, tick, (i % 2) == 0); end
    end
    checks++; if (div_active !== 32'd2) begin errors++; $display("FAIL d2_div_active: got %0d expected 2", div_active); end
  endtask
  task automatic test_load5();
    cyc();
    div_in = 32'd5; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    checks++; if (div_pending !== 1'b1) begin errors++; $display("FAIL l5_pending: got %b expected 1", div_pending); end
    checks++; if (div_active !== 32'd2) begin errors++; $display("FAIL l5_active_before: got %0d expected 2", div_active); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL l5_cout_old: got %b expected 0", cout); end
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (cout !== ((i % 5) < 3)) begin errors++; $display("FAIL d5_cout[%0d]: got %b expected %b", i, cout, (i % 5) < 3); end
      checks++; if (tick !== ((i % 5) == 0)) begin errors++; $display("FAIL d5_tick[%0d]: got %b expected %b", i, tick, (i % 5) == 0); end
    end
    chk("d5_div_active", div_active, 32'd5);
    chk("d5_pending_clear", {31'd0, div_pending}, 32'd0);
  endtask
  task automatic test_clamp();
    cyc();
    div_in = 32'd0; div_load = 1'b1;
    cyc();
    chk("clamp0_pending", {31'd0, div_pending}, 32'd1);
    div_in = 32'd1;
    cyc();
    div_load = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("clamp_active", div_active, 32'd2);
    chk("clamp_pending_clear", {31'd0, div_pending}, 32'd0);
    chk("clamp_tick", {31'd0, tick}, 32'd1);
    cyc();
    chk("clamp_cout_low", {31'd0, cout}, 32'd0);
    div_in = 32'd4; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    chk("bypass_active", div_active, 32'd4);
    chk("bypass_pending", {31'd0, div_pending}, 32'd0);
    chk("bypass_tick", {31'd0, tick}, 32'd1);
    for (int i = 1; i < 5; i++) begin
      cyc();
      chk($sformatf("d4_cout[%0d]", i), {31'd0, cout}, {31'd0, ((i % 4) < 2)});
      chk($sformatf("d4_tick[%0d]", i), {31'd0, tick}, {31'd0, ((i % 4) == 0)});
      chk($sformatf("d4_pending[%0d]", i), {31'd0, div_pending}, 32'd0);
    end
  endtask
  task automatic test_en_freeze();
    div_in = 32'd3; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("d3_active", div_active, 32'd3);
    chk("d3_tick_start", {31'd0, tick}, 32'd1);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("freeze_cout[%0d]", i), {31'd0, cout}, 32'd1);
      chk($sformatf("freeze_tick[%0d]", i), {31'd0, tick}, 32'd0);
    end
    en = 1'b1;
    cyc();
    chk("resume_cout_high", {31'd0, cout}, 32'd1);
    chk("resume_tick0", {31'd0, tick}, 32'd0);
    cyc();
    chk("resume_cout_low", {31'd0, cout}, 32'd0);
    cyc();
    chk("resume_boundary_cout", {31'd0, cout}, 32'd1);
    chk("resume_boundary_tick", {31'd0, tick}, 32'd1);
  endtask
  task automatic test_back_to_back();
    div_in = 32'd6; div_load = 1'b1;
    cyc();
    div_in = 32'd7;
    cyc();
    div_load = 1'b0;
    chk("b2b_pending", {31'd0, div_pending}, 32'd1);
    chk("b2b_active_old", div_active, 32'd3);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk($sformatf("d7_cout[%0d]", i), {31'd0, cout}, {31'd0, (i < 4)});
      chk($sformatf("d7_tick[%0d]", i), {31'd0, tick}, {31'd0, (i == 0)});
      chk($sformatf("d7_active[%0d]", i), div_active, 32'd7);
    end
  endtask
  task automatic test_reset_mid();
    cyc();
    cyc();
    div_in = 32'd9; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    chk("rm_pending_before", {31'd0, div_pending}, 32'd1);
    chk("rm_cout_before", {31'd0, cout}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rm_cout", {31'd0, cout}, 32'd0);
    chk("rm_tick", {31'd0, tick}, 32'd0);
    chk("rm_pending", {31'd0, div_pending}, 32'd0);
    chk("rm_active", div_active, 32'd2);
    cyc();
    chk("rm_hold_cout", {31'd0, cout}, 32'd0);
    @(negedge cin);
    rst = 1'b0;
    cyc();
    chk("rm_first_cout", {31'd0, cout}, 32'd1);
    chk("rm_first_tick", {31'd0, tick}, 32'd1);
    chk("rm_first_active", div_active, 32'd2);
    cyc();
    chk("rm_second_cout", {31'd0, cout}, 32'd0);
    chk("rm_second_pending", {31'd0, div_pending}, 32'd0);
  endtask
  initial begin
    test_reset();
    test_default();
    test_load5();
    test_clamp();
    test_en_freeze();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
